// File: rtl/mem_arbiter.sv
// Two-port (CPU / program loader) arbiter in front of a single fixed-latency memory port.
// Round-robin on ties; one access in flight at a time, IDLE -> ACCESS (LAT cycles) -> DONE.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              owner;       // 1 = loader, 0 = CPU
    logic              last_owner;  // port served by the most recent completed access
    logic              we_q;
    logic [DATA_W-1:0] rdata;
    logic              grant_ld;

    // Loader wins if it is alone, or on a tie when the CPU was served last.
    assign grant_ld = ld_req & (~cpu_req | ~last_owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_done   <= 1'b0;
            ld_done    <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            ld_done  <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req | ld_req) begin
                        owner     <= grant_ld;
                        we_q      <= grant_ld ? ld_we : cpu_we;
                        mem_addr  <= grant_ld ? ld_addr : cpu_addr;
                        mem_wdata <= grant_ld ? ld_wdata : cpu_wdata;
                        cnt       <= 4'(LAT - 1);
                        mem_en    <= 1'b1;
                        mem_we    <= grant_ld ? ld_we : cpu_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) rdata <= mem_rdata;
                        cpu_done <= ~owner;
                        ld_done  <= owner;
                        state    <= DONE;
                    end else begin
                        cnt    <= cnt - 4'd1;
                        mem_en <= 1'b1;
                        mem_we <= we_q;
                    end
                end
                DONE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_done;
    assign cpu_rdata = rdata;
    assign ld_rdata  = rdata;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-timeline model (grant cycle + fixed offsets) of the arbiter.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_done, cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0;
    logic              ld_done;
    logic [DATA_W-1:0] ld_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;
    logic [1:0]        dbg_state;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: one outstanding transaction described by its grant cycle.
    bit                act;
    int                t_start;
    bit                t_ld;
    bit                t_we;
    bit                last_ld;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic [DATA_W-1:0] exp_rdata;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        act       = 1'b0;
        last_ld   = 1'b1;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_rdata = '0;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        int   off;
        logic e_en, e_we, e_cd, e_ld, e_busy;
        e_en = 1'b0; e_we = 1'b0; e_cd = 1'b0; e_ld = 1'b0; e_busy = 1'b0;
        if (act) begin
            off = cyc - t_start;
            if (off >= 1 && off <= LAT) begin
                e_en = 1'b1; e_we = t_we; e_busy = 1'b1;
                if (off == LAT && !t_we) exp_q.push_back(mem_rdata);
            end else if (off == LAT + 1) begin
                e_busy = 1'b1;
                e_cd = !t_ld; e_ld = t_ld;
                if (!t_we && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
                last_ld = t_ld;
            end else if (off >= LAT + 2) begin
                act = 1'b0;
            end
        end
        check("mem_en", 64'(mem_en), 64'(e_en));
        check("mem_we", 64'(mem_we), 64'(e_we));
        check("busy", 64'(busy), 64'(e_busy));
        check("cpu_done", 64'(cpu_done), 64'(e_cd));
        check("ld_done", 64'(ld_done), 64'(e_ld));
        check("done_excl", 64'(cpu_done & ld_done), 64'd0);
        check("cpu_stall", 64'(cpu_stall), 64'(cpu_req & ~e_cd));
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        check("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
        check("ld_rdata", 64'(ld_rdata), 64'(exp_rdata));
        if (!act && (cpu_req || ld_req)) begin
            act     = 1'b1;
            t_start = cyc;
            t_ld    = ld_req && (!cpu_req || !last_ld);
            t_we    = t_ld ? ld_we : cpu_we;
            exp_addr  = t_ld ? ld_addr : cpu_addr;
            exp_wdata = t_ld ? ld_wdata : cpu_wdata;
        end
    endtask

    task automatic step(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd, input logic lr, input logic lw,
                        input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd,
                        input logic [DATA_W-1:0] mrd);
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ldd;
        mem_rdata = mrd;
        #1;
        model_cycle();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0; ld_req = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_done", 64'({cpu_done, ld_done}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // CPU read of 0x10
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF);
            if (i == 1) check("rd_addr_c1", 64'(mem_addr), 64'h10);
            if (i == 3) begin
                check("rd_done_c3", 64'(cpu_done), 64'd1);
                check("rd_stall_c3", 64'(cpu_stall), 64'd0);
                check("rd_data_c3", 64'(cpu_rdata), 64'hDEADBEEF);
            end
        end
        idle(3);

        // Loader write leaves rdata unchanged
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h12345678, 32'h55555555);
            if (i == 1) check("wr_we_c1", 64'(mem_we), 64'd1);
        end
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        check("wr_done_c3", 64'(ld_done), 64'd1);
        check("wr_rdata_kept", 64'(ld_rdata), 64'hDEADBEEF);
        idle(3);

        // Request dropped and address changed mid-access
        step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5A5A5A5);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 32'h99, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5A5A5A5);
            if (i == 2) check("drop_addr_c2", 64'(mem_addr), 64'h10);
            if (i == 3) check("drop_done_c3", 64'(cpu_done), 64'd1);
        end
        idle(3);

        // Reset in the middle of an access, then a tie
        do_reset();
        step(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        step(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h100 + i, 32'h0, 1, 0, 32'h200 + i, 32'h0, 32'hC0DE0000 + i);
            if (i == 3) check("tie_cpu_c3", 64'(cpu_done), 64'd1);
            if (i == 7) check("tie_ld_c7", 64'(ld_done), 64'd1);
        end
        idle(4);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                     $urandom);
            end
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
